// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster generator. It divides clk into a pixel
//            strobe and drives registered hsync/vsync/de and blanked colour.
//            Define VGA_TEST_PATTERN_EN to add pattern_sel (grey-bar override).
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter  int DIV      = 4,
    parameter  int H_ACTIVE = 640,
    parameter  int H_FP     = 16,
    parameter  int H_SYNC   = 96,
    parameter  int H_BP     = 48,
    parameter  int V_ACTIVE = 480,
    parameter  int V_FP     = 11,
    parameter  int V_SYNC   = 2,
    parameter  int V_BP     = 31,
    parameter  bit HS_POL   = 1'b1,
    parameter  bit VS_POL   = 1'b1,
    parameter  int CW       = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          resetn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    output logic          pix_ce,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          frame_start
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] c_DIV_LAST   = DW'(DIV - 1);
    localparam logic [XW-1:0] c_X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] c_Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] c_X_VIS_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] c_Y_VIS_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] c_HS_FIRST   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] c_HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] c_VS_FIRST   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] c_VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic [CW-1:0] b_q, b_d;

    logic          w_pix_ce;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_vis;
    logic          w_hs_act;
    logic          w_vs_act;
    logic [CW-1:0] w_r_src;
    logic [CW-1:0] w_g_src;
    logic [CW-1:0] w_b_src;

    assign w_pix_ce = (div_q == c_DIV_LAST);
    assign w_x_last = (x_q == c_X_LAST);
    assign w_y_last = (y_q == c_Y_LAST);

    // Inclusive upper bounds keep every constant inside the counter width.
    assign w_vis    = (x_q <= c_X_VIS_LAST) && (y_q <= c_Y_VIS_LAST);
    assign w_hs_act = (x_q >= c_HS_FIRST) && (x_q <= c_HS_LAST);
    assign w_vs_act = (y_q >= c_VS_FIRST) && (y_q <= c_VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
    logic [CW-1:0] w_bar;

    // Grey bars four pixels wide: bar level is the column divided by four.
    assign w_bar   = x_q[CW+1:2];
    assign w_r_src = pattern_sel ? w_bar : r_in;
    assign w_g_src = pattern_sel ? w_bar : g_in;
    assign w_b_src = pattern_sel ? w_bar : b_in;
`else
    assign w_r_src = r_in;
    assign w_g_src = g_in;
    assign w_b_src = b_in;
`endif

    always_comb begin
        div_d   = w_pix_ce ? '0 : div_q + 1'b1;
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        fs_d    = 1'b0;

        if (w_pix_ce) begin
            if (w_x_last) begin
                x_d = '0;
                y_d = w_y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end

            hsync_d = w_hs_act ? HS_POL : !HS_POL;
            vsync_d = w_vs_act ? VS_POL : !VS_POL;
            de_d    = w_vis;
            r_d     = w_vis ? w_r_src : '0;
            g_d     = w_vis ? w_g_src : '0;
            b_d     = w_vis ? w_b_src : '0;
            fs_d    = (x_q == '0) && (y_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= !HS_POL;
            vsync_q <= !VS_POL;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
        end
    end

    assign pix_ce      = w_pix_ce;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed bench for vga_timing_gen: default 640x480 build plus a
//            tiny DIV=1 raster used for whole-frame and mid-frame checks.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fr(input int i);
        return 2'((i * 3 + 1) % 4);
    endfunction
    function automatic logic [1:0] fg(input int i);
        return 2'((i + 2) % 4);
    endfunction
    function automatic logic [1:0] fb(input int i);
        return 2'((i * 5 + 3) % 4);
    endfunction

    // Default-parameter instance
    logic       def_rstn, def_psel, def_pce, def_hs, def_vs, def_de, def_fs;
    logic [9:0] def_x, def_y;
    logic [1:0] def_r_in, def_g_in, def_b_in, def_r, def_g, def_b;

    vga_timing_gen u_def (
        .clk         (clk),
        .resetn      (def_rstn),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (def_psel),
`endif
        .pix_ce      (def_pce),
        .x           (def_x),
        .y           (def_y),
        .r_in        (def_r_in),
        .g_in        (def_g_in),
        .b_in        (def_b_in),
        .hsync       (def_hs),
        .vsync       (def_vs),
        .de          (def_de),
        .r           (def_r),
        .g           (def_g),
        .b           (def_b),
        .frame_start (def_fs)
    );

    // Small raster: 16 px/line (8 visible), 7 lines/frame (4 visible)
    logic       sml_rstn, sml_psel, sml_pce, sml_hs, sml_vs, sml_de, sml_fs;
    logic [3:0] sml_x;
    logic [2:0] sml_y;
    logic [1:0] sml_r_in, sml_g_in, sml_b_in, sml_r, sml_g, sml_b;

    vga_timing_gen #(
        .DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(2)
    ) u_sml (
        .clk         (clk),
        .resetn      (sml_rstn),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (sml_psel),
`endif
        .pix_ce      (sml_pce),
        .x           (sml_x),
        .y           (sml_y),
        .r_in        (sml_r_in),
        .g_in        (sml_g_in),
        .b_in        (sml_b_in),
        .hsync       (sml_hs),
        .vsync       (sml_vs),
        .de          (sml_de),
        .r           (sml_r),
        .g           (sml_g),
        .b           (sml_b),
        .frame_start (sml_fs)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   t_de_fall, t_hs_rise, t_hs_fall, t_de_rise;
    logic pde, phs;
    int   p, l;
    logic e_de;

    initial begin
        def_rstn = 1'b0; def_psel = 1'b0;
        sml_rstn = 1'b0; sml_psel = 1'b0;
        def_r_in = 2'd0; def_g_in = 2'd0; def_b_in = 2'd0;
        sml_r_in = 2'd0; sml_g_in = 2'd0; sml_b_in = 2'd0;

        // ---------------- reset values ----------------
        repeat (10) @(negedge clk);
        check("def_rst_hsync", def_hs, 0);
        check("def_rst_vsync", def_vs, 0);
        check("def_rst_de", def_de, 0);
        check("def_rst_rgb", {def_r, def_g, def_b}, 0);
        check("def_rst_fs", def_fs, 0);
        check("def_rst_xy", {def_x, def_y}, 0);
        check("sml_rst_hsync", sml_hs, 1);
        check("sml_rst_vsync", sml_vs, 1);
        check("sml_rst_de", sml_de, 0);

        // ---------------- first strobe after release ----------------
        def_r_in = 2'd2; def_g_in = 2'd1; def_b_in = 2'd3;
        def_rstn = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("def_pce@%0d", i), def_pce, (i == 2));
            check($sformatf("def_fs@%0d", i), def_fs, (i == 3));
            check($sformatf("def_de@%0d", i), def_de, (i >= 3));
        end

        // ---------------- one line, default timing ----------------
        t_de_fall = -1; t_hs_rise = -1; t_hs_fall = -1; t_de_rise = -1;
        pde = def_de; phs = def_hs;
        for (int i = 6; i <= 3300; i++) begin
            @(negedge clk);
            if (pde && !def_de && t_de_fall < 0) t_de_fall = i;
            if (!pde && def_de && t_de_rise < 0) begin
                t_de_rise = i;
                check("def_next_line_y", def_y, 1);
            end
            if (!phs && def_hs && t_hs_rise < 0) t_hs_rise = i;
            if (phs && !def_hs && t_hs_fall < 0) t_hs_fall = i;
            if (i == 1000) check("def_vis_rgb", {def_r, def_g, def_b}, {2'd2, 2'd1, 2'd3});
            if (i == 2600) begin
                check("def_porch_rgb", {def_r, def_g, def_b}, 0);
                check("def_porch_hsync", def_hs, 0);
            end
            pde = def_de; phs = def_hs;
        end
        check("def_de_width", t_de_fall - 3, 2560);
        check("def_hs_offset", t_hs_rise - 3, 2624);
        check("def_hs_width", t_hs_fall - t_hs_rise, 384);
        check("def_line_period", t_de_rise - 3, 3200);
        check("def_vsync_line0", def_vs, 0);

        // ---------------- mid-frame reset, default ----------------
        for (int k = 0; k < 4000 && def_x != 10'd300; k++) @(negedge clk);
        check("def_seek_x", def_x, 300);
        check("def_seek_y", def_y, 1);
        def_rstn = 1'b0;
        @(negedge clk);
        def_rstn = 1'b1;
        check("def_mrst_xy", {def_x, def_y}, 0);
        check("def_mrst_hsync", def_hs, 0);
        check("def_mrst_vsync", def_vs, 0);
        check("def_mrst_de", def_de, 0);
        check("def_mrst_rgb", {def_r, def_g, def_b}, 0);
        check("def_mrst_fs", def_fs, 0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check($sformatf("def_mrst_fs@%0d", j), def_fs, (j == 4));
        end

        // ---------------- small raster: two frames plus ----------------
        sml_r_in = fr(0); sml_g_in = fg(0); sml_b_in = fb(0);
        sml_rstn = 1'b1;
        for (int i = 0; i <= 261; i++) begin
            @(negedge clk);
            p = i % 16;
            l = (i / 16) % 7;
            e_de = (p < 8) && (l < 4);
            check($sformatf("sml_pce@%0d", i), sml_pce, 1);
            check($sformatf("sml_x@%0d", i), sml_x, (i + 1) % 16);
            check($sformatf("sml_y@%0d", i), sml_y, ((i + 1) / 16) % 7);
            check($sformatf("sml_hsync@%0d", i), sml_hs, !(p >= 10 && p <= 12));
            check($sformatf("sml_vsync@%0d", i), sml_vs, (l != 5));
            check($sformatf("sml_de@%0d", i), sml_de, e_de);
            check($sformatf("sml_fs@%0d", i), sml_fs, (p == 0 && l == 0));
            check($sformatf("sml_rgb@%0d", i), {sml_r, sml_g, sml_b},
                  e_de ? {fr(i), fg(i), fb(i)} : 6'd0);
            sml_r_in = fr(i + 1); sml_g_in = fg(i + 1); sml_b_in = fb(i + 1);
        end

        // line 2, pixel 5 of the third frame: reset for one clk
        sml_rstn = 1'b0;
        @(negedge clk);
        check("sml_mrst_xy", {sml_x, sml_y}, 0);
        check("sml_mrst_hsync", sml_hs, 1);
        check("sml_mrst_vsync", sml_vs, 1);
        check("sml_mrst_de", sml_de, 0);
        check("sml_mrst_rgb", {sml_r, sml_g, sml_b}, 0);
        check("sml_mrst_fs", sml_fs, 0);
        sml_rstn = 1'b1;
        sml_r_in = fr(0); sml_g_in = fg(0); sml_b_in = fb(0);
        @(negedge clk);
        check("sml_restart_fs", sml_fs, 1);
        check("sml_restart_x", sml_x, 1);
        check("sml_restart_rgb", {sml_r, sml_g, sml_b}, {fr(0), fg(0), fb(0)});

`ifdef VGA_TEST_PATTERN_EN
        // ---------------- grey-bar pattern, default raster ----------------
        def_psel = 1'b1;
        def_r_in = 2'd3; def_g_in = 2'd3; def_b_in = 2'd3;
        def_rstn = 1'b0;
        @(negedge clk);
        def_rstn = 1'b1;
        for (int i = 0; i <= 2700; i++) begin
            @(negedge clk);
            if (i < 3) begin
                check($sformatf("pat_r@%0d", i), def_r, 0);
            end else if ((i - 3) % 4 == 0) begin
                p = (i - 3) / 4;
                check($sformatf("pat_rgb@%0d", i), {def_r, def_g, def_b},
                      (p < 640) ? {3{2'((p / 4) % 4)}} : 6'd0);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
